// File: rtl/fipsy_pin_driver_pkg.sv
// Shared definitions for the Fipsy pin driver: channel modes and
// configuration index width.
package fipsy_pin_driver_pkg;

  localparam int CH_IDX_W = 5;

  typedef enum logic [1:0] {
    MODE_LOW  = 2'd0,
    MODE_HIGH = 2'd1,
    MODE_HIZ  = 2'd2,
    MODE_PWM  = 2'd3
  } pin_mode_e;

endpackage

// File: rtl/fipsy_pin_driver_if.sv
// Configuration and pad-side bundle of the Fipsy pin driver.
// The master drives config and raw pad inputs; the slave is the driver.
interface fipsy_pin_driver_if #(
  parameter int NCH      = 12,
  parameter int PWM_BITS = 8
);
  import fipsy_pin_driver_pkg::*;

  logic                cfg_we;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;
  logic [NCH-1:0]      pin_in;
  logic [NCH-1:0]      pin_out;
  logic [NCH-1:0]      pin_oe;
  logic [NCH-1:0]      pin_sync;
  logic                pwm_wrap;
  logic                led_n;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_duty, pin_in,
    input  pin_out, pin_oe, pin_sync, pwm_wrap, led_n
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_duty, pin_in,
    output pin_out, pin_oe, pin_sync, pwm_wrap, led_n
  );

endinterface

// File: rtl/fipsy_pin_driver_pwm_chan.sv
// One pin channel: mode, double-buffered duty and registered pad drive.
// Active duty reloads from shadow only on the PWM wrap tick.
module fipsy_pin_driver_pwm_chan
  import fipsy_pin_driver_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  pin_mode_e           i_mode,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_wrap_tick,
  output logic                o_out,
  output logic                o_oe
);

  pin_mode_e           r_mode;
  logic [PWM_BITS-1:0] r_shadow_duty;
  logic [PWM_BITS-1:0] r_active_duty;
  logic                r_out;
  logic                r_oe;
  logic                w_out_next;
  logic                w_oe_next;

  always_comb begin
    w_out_next = 1'b0;
    w_oe_next  = 1'b1;
    case (r_mode)
      MODE_LOW:  w_out_next = 1'b0;
      MODE_HIGH: w_out_next = 1'b1;
      MODE_HIZ:  w_oe_next  = 1'b0;
      MODE_PWM:  w_out_next = (i_pwm_cnt < r_active_duty);
      default:   w_out_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode        <= MODE_LOW;
      r_shadow_duty <= '0;
      r_active_duty <= '0;
      r_out         <= 1'b0;
      r_oe          <= 1'b1;
    end else begin
      // A write on the wrap tick lands in shadow; active takes the old shadow.
      if (i_wrap_tick) r_active_duty <= r_shadow_duty;
      if (i_we) begin
        r_mode        <= i_mode;
        r_shadow_duty <= i_duty;
      end
      r_out <= w_out_next;
      r_oe  <= w_oe_next;
    end
  end

  assign o_out = r_out;
  assign o_oe  = r_oe;

endmodule

// File: rtl/fipsy_pin_driver.sv
// NCH-channel pin driver: shared PWM timebase, input synchronizers and a
// heartbeat LED; per-channel state lives in fipsy_pin_driver_pwm_chan.
module fipsy_pin_driver
  import fipsy_pin_driver_pkg::*;
#(
  parameter int NCH      = 12,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 8,
  parameter int HB_BITS  = 21
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fipsy_pin_driver_if.slave  bus
);

  localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PS_W-1:0]     r_prescale;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [HB_BITS-1:0]  r_hb_cnt;
  logic                r_led_n;
  logic                r_pwm_wrap;
  logic [NCH-1:0]      r_sync_meta;
  logic [NCH-1:0]      r_sync;
  logic                w_tick;
  logic                w_wrap_tick;
  logic [NCH-1:0]      w_ch_we;
  logic [NCH-1:0]      w_pin_out;
  logic [NCH-1:0]      w_pin_oe;

  assign w_tick      = (r_prescale == PS_MAX);
  assign w_wrap_tick = w_tick && (r_pwm_cnt == PWM_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prescale  <= '0;
      r_pwm_cnt   <= '0;
      r_hb_cnt    <= '0;
      r_led_n     <= 1'b0;
      r_pwm_wrap  <= 1'b0;
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_prescale  <= w_tick ? '0 : r_prescale + PS_W'(1);
      // Counter wraps max->0 naturally at its width.
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_hb_cnt    <= r_hb_cnt + HB_BITS'(1);
      r_led_n     <= r_hb_cnt[HB_BITS-1];
      r_pwm_wrap  <= w_wrap_tick;
      r_sync_meta <= bus.pin_in;
      r_sync      <= r_sync_meta;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    // Indices at or above NCH never match, so such writes are dropped.
    assign w_ch_we[gi] = bus.cfg_we && (bus.cfg_ch == CH_IDX_W'(gi));

    fipsy_pin_driver_pwm_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_we        (w_ch_we[gi]),
      .i_mode      (pin_mode_e'(bus.cfg_mode)),
      .i_duty      (bus.cfg_duty),
      .i_pwm_cnt   (r_pwm_cnt),
      .i_wrap_tick (w_wrap_tick),
      .o_out       (w_pin_out[gi]),
      .o_oe        (w_pin_oe[gi])
    );
  end

  assign bus.pin_out  = w_pin_out;
  assign bus.pin_oe   = w_pin_oe;
  assign bus.pin_sync = r_sync;
  assign bus.pwm_wrap = r_pwm_wrap;
  assign bus.led_n    = r_led_n;

endmodule

// File: doc/fipsy_pin_driver.md
Name: fipsy_pin_driver

Overview:
- Parametrised, NCH-channel pin driver for the Fipsy MachXO2 board. It replaces the hard-wired "all pins low, LED on" top-level behaviour.
- Each channel has a runtime-selectable mode: drive low, drive high, hi-Z input, or PWM. Hi-Z channels expose a synchronised input.
- LEDn carries a heartbeat derived from the system clock.
- Sits between the internal oscillator (OSCH, 2.08 MHz) and the top-level tristate pin buffers. The top level instantiates the inout buffers using PIN_OE and PIN_OUT.

Parameters:
- NCH, 12, number of pin channels (1..32)
- PWM_BITS, 8, PWM counter and duty width
- PRESCALE, 8, system clocks per PWM counter step (>=1)
- HB_BITS, 21, heartbeat counter width; LEDn toggles every 2^(HB_BITS-1) clocks (about 0.5 s at 2.08 MHz)

Ports:
- CLK  in  1  system clock (OSCH output)
- RSTn  in  1  asynchronous, active-low reset
- CFG_WE  in  1  config write strobe, one cycle per write
- CFG_CH  in  5  target channel index
- CFG_MODE  in  2  0=LOW, 1=HIGH, 2=HIZ, 3=PWM
- CFG_DUTY  in  PWM_BITS  PWM duty (high count per period)
- PIN_IN  in  NCH  raw pad inputs
- PIN_OUT  out  NCH  pad output data
- PIN_OE  out  NCH  pad output enable (1 = drive)
- PIN_SYNC  out  NCH  synchronised PIN_IN
- PWM_WRAP  out  1  one-cycle pulse when the PWM counter wraps to 0
- LEDn  out  1  heartbeat LED, active low

Behaviour:
- Clock and reset: one clock, CLK. RSTn is asynchronous assert, synchronous deassert (synchronised externally).
- Reset values:
  - mode[] = LOW, shadow_duty[] = 0, active_duty[] = 0
  - PIN_OUT = 0, PIN_OE = all 1s, so every pin is driven low out of reset
  - PIN_SYNC = 0, PWM_WRAP = 0
  - prescaler = 0, pwm_cnt = 0, hb_cnt = 0, LEDn = 0 (LED on)
- Config write:
  - On CFG_WE=1 with CFG_CH < NCH: mode[CFG_CH] <= CFG_MODE and shadow_duty[CFG_CH] <= CFG_DUTY.
  - CFG_CH >= NCH: write ignored, no state change.
  - No back-pressure; one write is accepted per cycle.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick = (prescaler == PRESCALE-1). PRESCALE=1 gives tick on every cycle.
- PWM counter:
  - pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0.
  - PWM_WRAP is registered; it is 1 in the cycle after the tick where pwm_cnt goes max->0.
- Duty update:
  - On the wrap tick, active_duty[i] <= shadow_duty[i] for all channels. This gives glitch-free duty changes.
  - A write coincident with the wrap tick lands in shadow only; active loads the pre-write shadow value. The new duty applies at the following wrap.
- Channel output (registered; reflects mode one cycle after the write, i.e. visible on the 2nd edge after CFG_WE):
  - LOW: OE=1, OUT=0
  - HIGH: OE=1, OUT=1
  - HIZ: OE=0, OUT=0
  - PWM: OE=1, OUT=(pwm_cnt < active_duty)
- PWM boundaries: duty=0 gives constant 0. duty=2^PWM_BITS-1 gives high for all but one step per period. There is no 100% mode; use HIGH.
- Mode change to or from PWM takes effect immediately, not on wrap. active_duty is unaffected.
- PIN_SYNC: 2-FF synchronizer per bit, latency 2 clocks, independent of mode.
- Heartbeat: hb_cnt increments every clock, free-running, and wraps. LEDn = hb_cnt[HB_BITS-1], registered.
- Reset mid-operation: everything returns to reset values asynchronously. Pins return to driven-low within the reset assertion, with no clock required.

Decomposition:
- Shared header fipsy_defs.vh holds:
  - mode localparams MODE_LOW=2'd0, MODE_HIGH=2'd1, MODE_HIZ=2'd2, MODE_PWM=2'd3
  - CH_IDX_W=5
- Sub-module fipsy_pwm_chan, generated NCH times. It holds mode, shadow/active duty and the output register, with inputs: write-enable, mode, duty, pwm_cnt, wrap_tick.
- The prescaler, pwm_cnt, heartbeat and synchronizers stay in fipsy_pin_driver.

Test Plan:
- Reset with PIN_IN toggling -> PIN_OE=all 1s, PIN_OUT=0, LEDn=0, PIN_SYNC=0 during and after reset.
- Write ch3 HIGH, then ch4 HIZ -> PIN_OUT[3]=1 and PIN_OE[4]=0, each 1 cycle after its write; PIN_IN[4] pulse appears on PIN_SYNC[4] 2 cycles later.
- PRESCALE=2, PWM_BITS=4, ch0 PWM duty=5 -> after the first PWM_WRAP, PIN_OUT[0] is high 10 clocks per 32-clock period; duty=0 gives constant 0; duty=15 gives 30/32 clocks high.
- Change ch0 duty 5->12 mid-period, including a write on the wrap tick itself -> the old duty persists until the next wrap (or the one after for a coincident write), with no glitches.
- CFG_CH=20 with NCH=12 -> no output changes on any channel.
- HB_BITS=4 -> LEDn toggles every 8 clocks; assert RSTn mid-PWM -> all outputs return to reset values asynchronously.
